i2c_reg_slave: RTL and testbench



---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_bus_sync.sv | 72 +++++++
 rtl/i2c_reg_slave.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register slave: FSM state encoding,
// ACK/NACK bit levels, and the byte returned for unmapped reads.
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        IDLE_WAIT,
        RX_CS,
        ACK_CS,
        RX_ADDR,
        ACK_ADDR,
        RX_DATA,
        ACK_DATA,
        TX_DATA,
        WAIT_ACK
    } state_t;

    localparam logic       BIT_ACK   = 1'b0;
    localparam logic       BIT_NACK  = 1'b1;
    localparam logic [7:0] READ_FILL = 8'hFF;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings SCL, SDA and en_sample into the clk domain and derives single-cycle
// event strobes from the synchronised levels.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   i_scl, i_sda    raw bus lines
//   i_en_sample     raw sample request
//   o_sda           synchronised SDA level
//   o_scl_rise/fall one-clk pulses on synchronised SCL edges
//   o_start/o_stop  bus START / STOP conditions
//   o_sample_rise   one-clk pulse on synchronised en_sample rising edge
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    input  logic i_en_sample,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sample_rise
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   r_en_d;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_en;

    // Bus lines reset to their idle-high level so that leaving reset with an
    // idle bus produces no spurious edge or START/STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_en_sync  <= '0;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_en_d     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], i_en_sample};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_en_d     <= w_en;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];
    assign w_en  = r_en_sync[SYNC_STAGES-1];

    assign o_sda         = w_sda;
    assign o_scl_rise    = w_scl & ~r_scl_d;
    assign o_scl_fall    = ~w_scl & r_scl_d;
    assign o_start       = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop        = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign o_sample_rise = w_en & ~r_en_d;

endmodule

// File: rtl/i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave
// I2C slave exposing NUM_REGS read/write bytes at BASE_ADDR.. and a read-only
// AD sample register at BASE_ADDR+NUM_REGS. Auto-increments the register
// pointer per data byte and supports random read through repeated START.
//
// Ports:
//   clk, rst    system clock (>= 8x SCL), async active-high reset
//   SCL, SDA    I2C bus; SDA is open-drain (0 or Z)
//   adc_data    AD conversion result, en_sample requests a capture
//   memory      flattened register file, reg k at [8k+7:8k]
//   tran_data   sample register
//   wr_strobe   one-clk pulse per committed write, wr_index its register
//   busy        high between START and STOP
// ---------------------------------------------------------------------------
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] CS_ADDR     = 7'h07,
    parameter logic [7:0] BASE_ADDR   = 8'h48,
    parameter int         NUM_REGS    = 3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCL,
    inout  wire                   SDA,
    input  logic [7:0]            adc_data,
    input  logic                  en_sample,
    output logic [8*NUM_REGS-1:0] memory,
    output logic [7:0]            tran_data,
    output logic                  wr_strobe,
    output logic [4:0]            wr_index,
    output logic                  busy
);

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic [7:0]            r_ptr;
    logic                  r_sda_low;
    logic                  r_loaded;
    logic                  r_pending;
    logic [8*NUM_REGS-1:0] r_mem;
    logic [7:0]            r_tran;
    logic                  r_wr_strobe;
    logic [4:0]            r_wr_index;
    logic                  r_busy;

    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_sample_rise;
    logic [7:0] w_off;
    logic       w_in_win;
    logic       w_is_sample;
    logic [7:0] w_ptr_next;
    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_byte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk           (clk),
        .rst           (rst),
        .i_scl         (SCL),
        .i_sda         (SDA),
        .i_en_sample   (en_sample),
        .o_sda         (w_sda),
        .o_scl_rise    (w_scl_rise),
        .o_scl_fall    (w_scl_fall),
        .o_start       (w_start),
        .o_stop        (w_stop),
        .o_sample_rise (w_sample_rise)
    );

    // Offset from BASE_ADDR wraps mod 256, so pointers below BASE land far
    // outside the window and one unsigned compare covers both bounds.
    assign w_off       = r_ptr - BASE_ADDR;
    assign w_in_win    = (w_off < 8'(NUM_REGS));
    assign w_is_sample = (w_off == 8'(NUM_REGS));
    assign w_ptr_next  = w_is_sample ? BASE_ADDR : r_ptr + 8'd1;
    assign w_rx_byte   = {r_shift[6:0], w_sda};

    always_comb begin
        w_rd_byte = READ_FILL;
        if (w_in_win) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_off == 8'(k)) w_rd_byte = r_mem[8*k +: 8];
            end
        end else if (w_is_sample) begin
            w_rd_byte = r_tran;
        end
    end

    // ACK states are entered on the SCL rise of bit 8: the next fall opens
    // the ACK slot and the rise inside the slot moves on, so SDA stays low
    // until the following fall is handled by the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_ptr       <= BASE_ADDR;
            r_sda_low   <= 1'b0;
            r_loaded    <= 1'b0;
            r_mem       <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= 5'd0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state   <= RX_CS;
                r_bit_cnt <= 3'd0;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state   <= IDLE;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    RX_CS, RX_ADDR, RX_DATA: begin
                        if (w_scl_fall) r_sda_low <= 1'b0;
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == RX_CS) begin
                                    r_state <= (w_rx_byte[7:1] == CS_ADDR) ? ACK_CS : IDLE_WAIT;
                                end else if (r_state == RX_ADDR) begin
                                    r_ptr   <= w_rx_byte;
                                    r_state <= ACK_ADDR;
                                end else begin
                                    if (w_in_win) begin
                                        for (int k = 0; k < NUM_REGS; k++) begin
                                            if (w_off == 8'(k)) r_mem[8*k +: 8] <= w_rx_byte;
                                        end
                                        r_wr_strobe <= 1'b1;
                                        r_wr_index  <= w_off[4:0];
                                    end
                                    r_ptr   <= w_ptr_next;
                                    r_state <= ACK_DATA;
                                end
                            end
                        end
                    end
                    ACK_CS, ACK_ADDR, ACK_DATA: begin
                        if (w_scl_fall) r_sda_low <= ~BIT_ACK;
                        if (w_scl_rise) begin
                            r_bit_cnt <= 3'd0;
                            r_loaded  <= 1'b0;
                            if (r_state == ACK_CS)
                                r_state <= r_shift[0] ? TX_DATA : RX_ADDR;
                            else
                                r_state <= RX_DATA;
                        end
                    end
                    TX_DATA: begin
                        if (w_scl_fall) begin
                            if (!r_loaded) begin
                                r_loaded  <= 1'b1;
                                r_shift   <= {w_rd_byte[6:0], 1'b0};
                                r_sda_low <= ~w_rd_byte[7];
                                r_bit_cnt <= 3'd0;
                            end else if (r_bit_cnt == 3'd7) begin
                                r_sda_low <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= WAIT_ACK;
                            end else begin
                                r_sda_low <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == BIT_ACK) begin
                                r_ptr    <= w_ptr_next;
                                r_loaded <= 1'b0;
                                r_state  <= TX_DATA;
                            end else begin
                                r_state <= IDLE_WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample capture is deferred to the end of a transaction so a master
    // never sees tran_data change between bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tran    <= 8'd0;
            r_pending <= 1'b0;
        end else if (w_stop && r_busy) begin
            if (r_pending || w_sample_rise) r_tran <= adc_data;
            r_pending <= 1'b0;
        end else if (w_sample_rise) begin
            if (r_busy || w_start) r_pending <= 1'b1;
            else                   r_tran    <= adc_data;
        end
    end

    assign SDA       = r_sda_low ? 1'b0 : 1'bz;
    assign memory    = r_mem;
    assign tran_data = r_tran;
    assign wr_strobe = r_wr_strobe;
    assign wr_index  = r_wr_index;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_slave
// Bit-banged I2C master driving i2c_reg_slave, checked against a register
// map model (array + pointer + sample value) kept in the bench.
// ---------------------------------------------------------------------------
module tb_i2c_reg_slave;

    localparam logic [7:0] BASE   = 8'h48;
    localparam int         NUM    = 3;
    localparam logic [7:0] SAMPLE = 8'h4B;
    localparam logic [7:0] CTRL_W = 8'h0E;
    localparam logic [7:0] CTRL_R = 8'h0F;
    localparam time        Q      = 50ns;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [7:0]  adc_data = 8'h00;
    logic        en_sample = 1'b0;
    logic [23:0] memory;
    logic [7:0]  tran_data;
    logic        wr_strobe;
    logic [4:0]  wr_index;
    logic        busy;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_reg_slave dut (
        .clk       (clk),
        .rst       (rst),
        .SCL       (scl),
        .SDA       (sda_bus),
        .adc_data  (adc_data),
        .en_sample (en_sample),
        .memory    (memory),
        .tran_data (tran_data),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always #5ns clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_mem [0:NUM-1];
    logic [7:0] model_ptr;
    logic [7:0] model_tran;
    logic [4:0] exp_idx [$];
    logic [4:0] strobe_q [$];

    always @(negedge clk) if (wr_strobe) strobe_q.push_back(wr_index);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [7:0] p);
        return (p >= BASE) && (p < SAMPLE);
    endfunction

    function automatic logic [7:0] nxt(input logic [7:0] p);
        return (p == SAMPLE) ? BASE : p + 8'd1;
    endfunction

    function automatic logic [7:0] rd_val(input logic [7:0] p);
        if (in_win(p)) return model_mem[p - BASE];
        if (p == SAMPLE) return model_tran;
        return 8'hFF;
    endfunction

    function automatic logic [23:0] model_flat();
        return {model_mem[2], model_mem[1], model_mem[0]};
    endfunction

    task automatic i2c_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; #Q;
            scl = 1'b1;        #(2*Q);
            scl = 1'b0;        #Q;
        end
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        ack = sda_bus;    #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic send_ack);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            scl = 1'b1;    #Q;
            b[i] = sda_bus; #Q;
            scl = 1'b0;    #Q;
        end
        m_sda_low = send_ack; #Q;
        scl = 1'b1;           #(2*Q);
        scl = 1'b0;           #Q;
        m_sda_low = 1'b0;
    endtask

    task automatic pulse_sample();
        en_sample = 1'b1; #80ns;
        en_sample = 1'b0; #80ns;
    endtask

    task automatic txn_open(input logic [7:0] addr);
        logic ack;
        strobe_q.delete();
        exp_idx.delete();
        i2c_start();
        write_byte(CTRL_W, ack);
        check("ack_ctrl_w", ack, 1'b0);
        write_byte(addr, ack);
        check("ack_addr", ack, 1'b0);
        model_ptr = addr;
    endtask

    task automatic txn_data(input logic [7:0] b);
        logic ack;
        write_byte(b, ack);
        check("ack_data", ack, 1'b0);
        if (in_win(model_ptr)) begin
            model_mem[model_ptr - BASE] = b;
            exp_idx.push_back(5'(model_ptr - BASE));
        end
        model_ptr = nxt(model_ptr);
    endtask

    task automatic txn_close();
        i2c_stop();
        #Q;
        check("busy_after_stop", busy, 1'b0);
        check("strobe_count", strobe_q.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < strobe_q.size(); i++)
            check("wr_index", strobe_q[i], exp_idx[i]);
        check("memory", memory, model_flat());
    endtask

    task automatic read_txn(input logic [7:0] addr, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        write_byte(CTRL_W, ack);
        check("rd_ack_ctrl_w", ack, 1'b0);
        write_byte(addr, ack);
        check("rd_ack_addr", ack, 1'b0);
        model_ptr = addr;
        i2c_start();
        write_byte(CTRL_R, ack);
        check("rd_ack_ctrl_r", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            check("rd_byte", b, rd_val(model_ptr));
            if (i != n - 1) model_ptr = nxt(model_ptr);
        end
        check("rel_after_nack", sda_bus, 1'b1);
        i2c_stop();
        #Q;
    endtask

    initial begin
        logic       ack;
        logic [7:0] addr;
        logic [7:0] addr_pick [0:6];

        for (int i = 0; i < NUM; i++) model_mem[i] = 8'h00;
        model_ptr  = BASE;
        model_tran = 8'h00;

        #100ns;
        @(negedge clk);
        check("rst_memory", memory, 24'h0);
        check("rst_tran", tran_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_index", wr_index, 5'd0);
        check("rst_sda", sda_bus, 1'b1);
        rst = 1'b0;
        #Q;

        // Burst write with auto-increment.
        txn_open(BASE);
        check("busy_in_txn", busy, 1'b1);
        txn_data(8'h11);
        txn_data(8'h22);
        txn_data(8'h33);
        txn_close();
        check("memory_fixed", memory, 24'h332211);

        // Idle sample capture.
        adc_data = 8'hAA;
        pulse_sample();
        model_tran = 8'hAA;
        check("tran_idle", tran_data, model_tran);

        // Random read and wrapping read.
        read_txn(8'h49, 2);
        read_txn(8'h49, 5);

        // Wrong device select is ignored until STOP.
        i2c_start();
        write_byte(8'h10, ack);
        check("nack_cs", ack, 1'b1);
        write_byte(BASE, ack);
        check("ignored_addr", ack, 1'b1);
        write_byte(8'h99, ack);
        check("ignored_data", ack, 1'b1);
        i2c_stop();
        #Q;
        check("memory_after_bad_cs", memory, model_flat());
        txn_open(BASE + 8'd2);
        txn_data(8'($urandom));
        txn_close();

        // Sample request during a transaction is deferred to STOP.
        txn_open(BASE);
        adc_data = 8'h33;
        pulse_sample();
        check("tran_hold_1", tran_data, model_tran);
        txn_data(8'($urandom));
        adc_data = 8'h5C;
        check("tran_hold_2", tran_data, model_tran);
        model_tran = 8'h5C;
        txn_close();
        check("tran_after_stop", tran_data, model_tran);

        // Random writes (inside, at, and outside the window) with read-back.
        addr_pick[0] = 8'h47; addr_pick[1] = 8'h48; addr_pick[2] = 8'h49;
        addr_pick[3] = 8'h4A; addr_pick[4] = 8'h4B; addr_pick[5] = 8'h4C;
        addr_pick[6] = 8'hFE;
        for (int t = 0; t < 5; t++) begin
            addr = addr_pick[$urandom_range(6, 0)];
            txn_open(addr);
            for (int j = 0; j < int'($urandom_range(4, 1)); j++) txn_data(8'($urandom));
            txn_close();
            read_txn(addr_pick[$urandom_range(6, 0)], int'($urandom_range(5, 1)));
        end

        // Reset in the middle of the address byte.
        txn_open(BASE);
        txn_data(8'hA5);
        txn_close();
        i2c_start();
        write_byte(CTRL_W, ack);
        for (int i = 7; i >= 5; i--) begin
            m_sda_low = ~BASE[i]; #Q;
            scl = 1'b1;           #(2*Q);
            scl = 1'b0;           #Q;
        end
        m_sda_low = ~BASE[4]; #Q;
        scl = 1'b1;           #Q;
        rst = 1'b1;
        m_sda_low = 1'b0;     #Q;
        check("rstmid_sda", sda_bus, 1'b1);
        check("rstmid_memory", memory, 24'h0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_tran", tran_data, 8'h00);
        rst = 1'b0;           #Q;
        for (int i = 0; i < NUM; i++) model_mem[i] = 8'h00;
        model_tran = 8'h00;
        txn_open(BASE);
        for (int j = 0; j < NUM; j++) txn_data(8'($urandom));
        txn_close();
        read_txn(BASE, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
